// File: rtl/im_pkg.sv
// Shared types and helpers for the instruction-memory SRAM controller.
package im_pkg;

    typedef enum logic [1:0] {
        StRd,
        StWSetup,
        StWLow,
        StWHold
    } im_state_e;

    localparam int unsigned WLOW_CNT_W = 3;
    localparam int unsigned MAX_ADDR_W = 32;

    // Zero-fill every bit at or above addr_w so narrow addresses map onto wider SRAM pins.
    function automatic logic [MAX_ADDR_W-1:0] addr_ext(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned addr_w);
        logic [MAX_ADDR_W-1:0] ext;
        ext = '0;
        for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
            if (i < addr_w) ext[i] = addr[i];
        end
        return ext;
    endfunction

endpackage

// File: rtl/im_wbuf.sv
// Write buffer: synchronous FIFO with a parallel address-compare port for read-after-write
// forwarding; the newest matching entry wins.
module im_wbuf #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              single_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;
    logic [PTR_W-1:0]  idx;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign single_o    = (count_q == CNT_W'(1));
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // A push into a full buffer is legal only when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // Walk oldest to newest so a later match overrides an earlier one.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == cmp_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= wr_addr_i;
            data_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/im_sram_ctrl.sv
// Instruction-memory controller for the Ram2 SRAM: combinational fetches, buffered writes
// drained with a registered WE pulse, and forwarding of pending writes to fetches.
module im_sram_ctrl
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WBUF_DEPTH  = 4,
    parameter int unsigned WE_LOW_CYC  = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ADDR_W-1:0]      FetchAddr,
    output logic [DATA_W-1:0]      InsOut,
    output logic                   InsValid,
    input  logic                   WrReq,
    input  logic [ADDR_W-1:0]      WrAddr,
    input  logic [DATA_W-1:0]      WrData,
    output logic                   WrReady,
    output logic                   WrOverflow,
    output logic                   WrIdle,
    output logic                   Ram2_EN,
    output logic                   Ram2_OE,
    output logic                   Ram2_WE,
    output logic [SRAM_ADDR_W-1:0] Ram2_address,
    inout  wire logic [DATA_W-1:0] Ram2_data
);

    im_state_e             state_q, state_d;
    logic [WLOW_CNT_W-1:0] cnt_q, cnt_d;
    logic                  oe_q, oe_d;
    logic                  we_q, we_d;
    logic                  ovf_q, ovf_d;

    logic                  full, empty, single, hit, push, pop, drive;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data, hit_data;

    im_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .push_i      (push),
        .pop_i       (pop),
        .wr_addr_i   (WrAddr),
        .wr_data_i   (WrData),
        .cmp_addr_i  (FetchAddr),
        .full_o      (full),
        .empty_o     (empty),
        .single_o    (single),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .hit_o       (hit),
        .hit_data_o  (hit_data)
    );

    // The WHOLD pop frees a slot on the same edge, so a full buffer can still accept then.
    assign pop     = (state_q == StWHold);
    assign WrReady = !full || pop;
    assign push    = WrReq && WrReady;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRd: begin
                if (!empty) state_d = StWSetup;
            end
            StWSetup: begin
                state_d = StWLow;
                cnt_d   = WLOW_CNT_W'(WE_LOW_CYC - 1);
            end
            StWLow: begin
                if (cnt_q == '0) state_d = StWHold;
                else             cnt_d   = cnt_q - WLOW_CNT_W'(1);
            end
            StWHold: begin
                state_d = (single && !push) ? StRd : StWSetup;
            end
            default: state_d = StRd;
        endcase
        // Strobes are derived from the next state so the pins come straight off flops.
        oe_d  = (state_d != StRd);
        we_d  = (state_d != StWLow);
        ovf_d = ovf_q || (WrReq && !WrReady);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StRd;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            we_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
        end
    end

    assign drive        = (state_q != StRd);
    assign Ram2_EN      = 1'b0;
    assign Ram2_OE      = oe_q;
    assign Ram2_WE      = we_q;
    assign Ram2_data    = drive ? head_data : {DATA_W{1'bz}};
    assign Ram2_address = drive ? SRAM_ADDR_W'(addr_ext(MAX_ADDR_W'(head_addr), ADDR_W))
                                : SRAM_ADDR_W'(addr_ext(MAX_ADDR_W'(FetchAddr), ADDR_W));

    assign InsValid   = hit || (state_q == StRd);
    assign InsOut     = hit ? hit_data : Ram2_data;
    assign WrOverflow = ovf_q;
    assign WrIdle     = empty && (state_q == StRd);

endmodule

// File: tb/tb_im_sram_ctrl.sv
// Directed bench for im_sram_ctrl with a behavioural asynchronous SRAM on the Ram2 pins.
module tb_im_sram_ctrl;

    logic        Clk;
    logic        Rst;
    logic [15:0] FetchAddr;
    logic [15:0] InsOut;
    logic        InsValid;
    logic        WrReq;
    logic [15:0] WrAddr;
    logic [15:0] WrData;
    logic        WrReady;
    logic        WrOverflow;
    logic        WrIdle;
    logic        Ram2_EN;
    logic        Ram2_OE;
    logic        Ram2_WE;
    logic [17:0] Ram2_address;
    wire  [15:0] Ram2_data;

    logic [15:0] mem [65536];
    int          n_cmp = 0;
    int          n_err = 0;
    int          falls = 0;
    int          f0;

    im_sram_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .SRAM_ADDR_W (18),
        .WBUF_DEPTH  (4),
        .WE_LOW_CYC  (2)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .FetchAddr    (FetchAddr),
        .InsOut       (InsOut),
        .InsValid     (InsValid),
        .WrReq        (WrReq),
        .WrAddr       (WrAddr),
        .WrData       (WrData),
        .WrReady      (WrReady),
        .WrOverflow   (WrOverflow),
        .WrIdle       (WrIdle),
        .Ram2_EN      (Ram2_EN),
        .Ram2_OE      (Ram2_OE),
        .Ram2_WE      (Ram2_WE),
        .Ram2_address (Ram2_address),
        .Ram2_data    (Ram2_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // SRAM drives only while selected for read; it stores whatever is on the bus while WE is low.
    assign Ram2_data = (!Ram2_EN && !Ram2_OE && Ram2_WE) ? mem[Ram2_address[15:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        forever begin
            @(negedge Clk);
            if (!Ram2_EN && !Ram2_WE) mem[Ram2_address[15:0]] = Ram2_data;
        end
    end

    always @(negedge Ram2_WE) falls++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (!WrIdle && k < max_cyc) begin
            step();
            k++;
        end
        chk("drain_idle", 32'(WrIdle), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; WrReq = 1'b0; WrAddr = '0; WrData = '0; FetchAddr = 16'h0010;
        repeat (2) @(posedge Clk);
        #1;
        // 1. reset state
        chk("rst_oe", 32'(Ram2_OE), 32'd0);
        chk("rst_we", 32'(Ram2_WE), 32'd1);
        chk("rst_bus_released", 32'(Ram2_data), 32'(pat(16'h0010)));
        Rst = 1'b0;
        step();
        chk("rst_wrready", 32'(WrReady), 32'd1);
        chk("rst_wridle", 32'(WrIdle), 32'd1);
        chk("rst_ovf", 32'(WrOverflow), 32'd0);
        chk("rst_en", 32'(Ram2_EN), 32'd0);
        chk("fetch_addr_pins", 32'(Ram2_address), 32'h10);
        chk("fetch_valid", 32'(InsValid), 32'd1);
        chk("fetch_data", 32'(InsOut), 32'(pat(16'h0010)));

        // 2. single write, WE low for exactly two cycles
        f0 = falls;
        WrReq = 1'b1; WrAddr = 16'h0020; WrData = 16'hBEEF;
        step();
        WrReq = 1'b0;
        #1;
        chk("w1_busy", 32'(WrIdle), 32'd0);
        chk("w1_rd_oe", 32'(Ram2_OE), 32'd0);
        chk("w1_rd_valid", 32'(InsValid), 32'd1);
        step();
        chk("w1_setup_oe", 32'(Ram2_OE), 32'd1);
        chk("w1_setup_we", 32'(Ram2_WE), 32'd1);
        chk("w1_setup_addr", 32'(Ram2_address), 32'h20);
        chk("w1_setup_data", 32'(Ram2_data), 32'hBEEF);
        chk("w1_setup_nohit_valid", 32'(InsValid), 32'd0);
        step();
        chk("w1_low1_we", 32'(Ram2_WE), 32'd0);
        chk("w1_low1_addr", 32'(Ram2_address), 32'h20);
        chk("w1_low1_data", 32'(Ram2_data), 32'hBEEF);
        FetchAddr = 16'h0020;
        #1;
        chk("w1_fwd_valid", 32'(InsValid), 32'd1);
        chk("w1_fwd_data", 32'(InsOut), 32'hBEEF);
        step();
        chk("w1_low2_we", 32'(Ram2_WE), 32'd0);
        step();
        chk("w1_hold_we", 32'(Ram2_WE), 32'd1);
        chk("w1_hold_addr", 32'(Ram2_address), 32'h20);
        chk("w1_hold_data", 32'(Ram2_data), 32'hBEEF);
        step();
        chk("w1_idle", 32'(WrIdle), 32'd1);
        chk("w1_pulses", 32'(falls - f0), 32'd1);
        chk("w1_readback", 32'(InsOut), 32'hBEEF);
        chk("w1_readback_valid", 32'(InsValid), 32'd1);

        // 3. forwarding picks the newest of two matching entries
        FetchAddr = 16'h0010;
        WrReq = 1'b1; WrAddr = 16'h0030; WrData = 16'h1111;
        step();
        WrData = 16'h2222;
        step();
        WrReq = 1'b0; FetchAddr = 16'h0030;
        #1;
        chk("fwd_newest_data", 32'(InsOut), 32'h2222);
        chk("fwd_newest_valid", 32'(InsValid), 32'd1);
        FetchAddr = 16'h0040;
        #1;
        chk("fwd_miss_valid", 32'(InsValid), 32'd0);
        wait_idle(40);
        FetchAddr = 16'h0030;
        #1;
        chk("fwd_final_mem", 32'(InsOut), 32'h2222);

        // 4. burst of depth+1: last request dropped, sticky overflow
        FetchAddr = 16'h0010;
        f0 = falls;
        for (int i = 0; i < 5; i++) begin
            WrReq = 1'b1; WrAddr = 16'(16'h0050 + i); WrData = 16'(16'h5000 + i);
            #1;
            if (i == 3) chk("burst_ready_before_full", 32'(WrReady), 32'd1);
            if (i == 4) chk("burst_ready_full", 32'(WrReady), 32'd0);
            step();
        end
        WrReq = 1'b0;
        #1;
        chk("burst_ovf", 32'(WrOverflow), 32'd1);
        wait_idle(60);
        chk("burst_pulses", 32'(falls - f0), 32'd4);
        chk("burst_ovf_sticky", 32'(WrOverflow), 32'd1);
        FetchAddr = 16'h0053;
        #1;
        chk("burst_last_kept", 32'(InsOut), 32'h5003);
        FetchAddr = 16'h0054;
        #1;
        chk("burst_dropped", 32'(InsOut), 32'(pat(16'h0054)));

        Rst = 1'b1;
        #1;
        chk("rst_clears_ovf", 32'(WrOverflow), 32'd0);
        step();
        Rst = 1'b0;
        step();

        // 5. push on the WHOLD pop edge while full
        FetchAddr = 16'h0010;
        f0 = falls;
        for (int i = 0; i < 4; i++) begin
            WrReq = 1'b1; WrAddr = 16'(16'h0060 + i); WrData = 16'(16'h6000 + i);
            step();
        end
        WrReq = 1'b0;
        #1;
        chk("pp_full_ready", 32'(WrReady), 32'd0);
        step();
        chk("pp_hold_addr", 32'(Ram2_address), 32'h60);
        chk("pp_hold_ready", 32'(WrReady), 32'd1);
        WrReq = 1'b1; WrAddr = 16'h0064; WrData = 16'h6004;
        step();
        WrReq = 1'b0;
        #1;
        chk("pp_setup_oe", 32'(Ram2_OE), 32'd1);
        chk("pp_setup_we", 32'(Ram2_WE), 32'd1);
        chk("pp_next_head", 32'(Ram2_address), 32'h61);
        chk("pp_still_full", 32'(WrReady), 32'd0);
        chk("pp_no_ovf", 32'(WrOverflow), 32'd0);
        wait_idle(80);
        chk("pp_pulses", 32'(falls - f0), 32'd5);
        FetchAddr = 16'h0064;
        #1;
        chk("pp_pushed_written", 32'(InsOut), 32'h6004);
        FetchAddr = 16'h0060;
        #1;
        chk("pp_first_written", 32'(InsOut), 32'h6000);

        // 6. reset during WLOW releases the bus at once
        FetchAddr = 16'h0010;
        f0 = falls;
        WrReq = 1'b1; WrAddr = 16'h0070; WrData = 16'h7777;
        step();
        WrReq = 1'b0;
        step();
        step();
        chk("mid_we_low", 32'(Ram2_WE), 32'd0);
        Rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(Ram2_WE), 32'd1);
        chk("mid_rst_oe", 32'(Ram2_OE), 32'd0);
        chk("mid_rst_bus", 32'(Ram2_data), 32'(pat(16'h0010)));
        chk("mid_rst_idle", 32'(WrIdle), 32'd1);
        step();
        Rst = 1'b0;
        repeat (10) step();
        chk("mid_no_more_pulses", 32'(falls - f0), 32'd1);
        chk("mid_ready", 32'(WrReady), 32'd1);
        chk("mid_idle", 32'(WrIdle), 32'd1);
        chk("mid_fetch", 32'(InsOut), 32'(pat(16'h0010)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
